// File: rtl/pm_loader_pkg.sv
// Shared types and constants for the program-memory loader.
// Both the RTL and the bench import this package.
package pm_loader_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LEN      = 3'd1,
        DATA     = 3'd2,
        CSUM     = 3'd3,
        ERR_WAIT = 3'd4
    } state_t;

    localparam int unsigned LEN_ZERO_COUNT = 256;
    localparam int unsigned COUNT_W        = 9;

    // A length byte of zero encodes a full 256-byte image.
    function automatic logic [COUNT_W-1:0] count_from_len(input logic [7:0] len);
        return (len == 8'd0) ? COUNT_W'(LEN_ZERO_COUNT) : {1'b0, len};
    endfunction

endpackage

// File: rtl/pm_loader_if.sv
// Byte-stream input and program-memory write port of the loader.
// The loader uses the slave view; the byte source and memory use the master view.
interface pm_loader_if;

    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       pm_wr_en;
    logic [7:0] pm_wr_addr;
    logic [7:0] pm_wr_data;

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output pm_wr_en,
        output pm_wr_addr,
        output pm_wr_data
    );

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  pm_wr_en,
        input  pm_wr_addr,
        input  pm_wr_data
    );

endinterface

// File: rtl/pm_loader.sv
// Loads a length-prefixed, checksummed byte stream into program memory
// while holding the CPU in reset.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for load_req; CPU released
// LEN      | expecting the length byte (0 means 256)
// DATA     | accepting payload bytes, one memory write per byte
// CSUM     | expecting the checksum byte; sets done or error
// ERR_WAIT | one cycle after a bad checksum, CPU still held
module pm_loader
    import pm_loader_pkg::*;
#(
    parameter logic [7:0] START_ADDR = 8'h00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_req,
    pm_loader_if.slave  bus,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);

    state_t               state, state_nxt;
    logic [COUNT_W-1:0]   count, count_nxt;
    logic [7:0]           addr, addr_nxt;
    logic [7:0]           acc, acc_nxt;
    logic                 wr_en, wr_en_nxt;
    logic [7:0]           wr_addr, wr_addr_nxt;
    logic [7:0]           wr_data, wr_data_nxt;
    logic                 done_nxt, error_nxt;
    logic                 ready;
    logic [7:0]           sum;

    assign sum            = acc + bus.in_data;
    assign bus.in_ready   = ready;
    assign bus.pm_wr_en   = wr_en;
    assign bus.pm_wr_addr = wr_addr;
    assign bus.pm_wr_data = wr_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            count   <= '0;
            addr    <= 8'h00;
            acc     <= 8'h00;
            wr_en   <= 1'b0;
            wr_addr <= 8'h00;
            wr_data <= 8'h00;
            done    <= 1'b0;
            error   <= 1'b0;
        end else begin
            state   <= state_nxt;
            count   <= count_nxt;
            addr    <= addr_nxt;
            acc     <= acc_nxt;
            wr_en   <= wr_en_nxt;
            wr_addr <= wr_addr_nxt;
            wr_data <= wr_data_nxt;
            done    <= done_nxt;
            error   <= error_nxt;
        end
    end

    // In LEN/DATA/CSUM ready is 1, so in_valid alone marks a transfer there.
    always_comb begin
        state_nxt   = state;
        count_nxt   = count;
        addr_nxt    = addr;
        acc_nxt     = acc;
        wr_en_nxt   = 1'b0;
        wr_addr_nxt = wr_addr;
        wr_data_nxt = wr_data;
        done_nxt    = done;
        error_nxt   = error;
        ready       = 1'b0;
        cpu_hold    = 1'b1;

        case (state)
            IDLE: begin
                cpu_hold = 1'b0;
                if (load_req) begin
                    state_nxt = LEN;
                    done_nxt  = 1'b0;
                    error_nxt = 1'b0;
                end
            end
            LEN: begin
                ready = 1'b1;
                if (bus.in_valid) begin
                    count_nxt = count_from_len(bus.in_data);
                    addr_nxt  = START_ADDR;
                    acc_nxt   = 8'h00;
                    state_nxt = DATA;
                end
            end
            DATA: begin
                ready = 1'b1;
                if (bus.in_valid) begin
                    wr_en_nxt   = 1'b1;
                    wr_addr_nxt = addr;
                    wr_data_nxt = bus.in_data;
                    addr_nxt    = addr + 8'd1;
                    acc_nxt     = sum;
                    count_nxt   = count - COUNT_W'(1);
                    if (count == COUNT_W'(1)) begin
                        state_nxt = CSUM;
                    end
                end
            end
            CSUM: begin
                ready = 1'b1;
                if (bus.in_valid) begin
                    if (sum == 8'h00) begin
                        done_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        error_nxt = 1'b1;
                        state_nxt = ERR_WAIT;
                    end
                end
            end
            ERR_WAIT: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_pm_loader.sv
// Bench for pm_loader: two instances (start 00 and FE) share one stimulus
// stream and are checked against a byte-list model of the expected writes.
module tb_pm_loader;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       load_req = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       cpu_hold0, done0, error0;
    logic       cpu_hold1, done1, error1;

    int errors = 0;
    int checks = 0;

    logic [15:0] obs0[$];
    logic [15:0] obs1[$];

    always #5 clk = ~clk;

    pm_loader_if ifc0();
    pm_loader_if ifc1();

    assign ifc0.in_valid = in_valid;
    assign ifc0.in_data  = in_data;
    assign ifc1.in_valid = in_valid;
    assign ifc1.in_data  = in_data;

    pm_loader #(.START_ADDR(8'h00)) dut0 (
        .clk      (clk),
        .reset    (reset),
        .load_req (load_req),
        .bus      (ifc0.slave),
        .cpu_hold (cpu_hold0),
        .done     (done0),
        .error    (error0)
    );

    pm_loader #(.START_ADDR(8'hFE)) dut1 (
        .clk      (clk),
        .reset    (reset),
        .load_req (load_req),
        .bus      (ifc1.slave),
        .cpu_hold (cpu_hold1),
        .done     (done1),
        .error    (error1)
    );

    always @(negedge clk) begin
        if (ifc0.pm_wr_en === 1'b1) obs0.push_back({ifc0.pm_wr_addr, ifc0.pm_wr_data});
        if (ifc1.pm_wr_en === 1'b1) obs1.push_back({ifc1.pm_wr_addr, ifc1.pm_wr_data});
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", name, observed, expected);
        end
    endtask

    // Model: a load passes when payload bytes plus checksum sum to 0 mod 256.
    function automatic bit model_ok(input logic [7:0] pl[$], input logic [7:0] csum);
        int s = csum;
        foreach (pl[i]) s += pl[i];
        return (s % 256) == 0;
    endfunction

    function automatic logic [7:0] good_csum(input logic [7:0] pl[$]);
        int s = 0;
        foreach (pl[i]) s += pl[i];
        return 8'((256 - (s % 256)) % 256);
    endfunction

    task automatic compare_writes(input string name, input logic [7:0] start,
                                  input logic [7:0] pl[$], input logic [15:0] obs[$]);
        logic [15:0] exp_q[$];
        int bad = -1;
        foreach (pl[i]) exp_q.push_back({8'((int'(start) + i) % 256), pl[i]});
        check({name, "_count"}, obs.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            if (bad < 0 && obs[i] !== exp_q[i]) bad = i;
        end
        if (bad >= 0) check({name, "_entry"}, obs[bad], exp_q[bad]);
        else check({name, "_first_bad"}, bad, -1);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int guard = 0;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                in_valid = 1'b0;
                in_data  = 8'($urandom);
            end
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        while (ifc0.in_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) begin
            check("ready_timeout", ifc0.in_ready, 1'b1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic pulse_load();
        @(negedge clk);
        load_req = 1'b1;
        @(posedge clk);
        #1;
        load_req = 1'b0;
        check("start_hold", {cpu_hold0, cpu_hold1}, 2'b11);
        check("start_clear", {done0, error0, done1, error1}, 4'b0000);
    endtask

    task automatic run_load(input logic [7:0] len_byte, input logic [7:0] pl[$],
                            input logic [7:0] csum, input bit gaps, input bit poke_req);
        bit ok;
        obs0.delete();
        obs1.delete();
        pulse_load();
        send_byte(len_byte, gaps);
        foreach (pl[i]) begin
            if (poke_req) load_req = 1'($urandom_range(0, 1));
            send_byte(pl[i], gaps);
        end
        load_req = 1'b0;
        send_byte(csum, gaps);
        ok = model_ok(pl, csum);
        check("done", {done0, done1}, ok ? 2'b11 : 2'b00);
        check("error", {error0, error1}, ok ? 2'b00 : 2'b11);
        check("hold_after_csum", {cpu_hold0, cpu_hold1}, ok ? 2'b00 : 2'b11);
        @(posedge clk);
        #1;
        check("back_to_idle", {cpu_hold0, cpu_hold1, ifc0.in_ready, ifc1.in_ready}, 4'b0000);
        compare_writes("writes_s00", 8'h00, pl, obs0);
        compare_writes("writes_sfe", 8'hFE, pl, obs1);
    endtask

    initial begin
        logic [7:0] pl[$];
        logic [7:0] cs;
        int n;

        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs0", {ifc0.in_ready, ifc0.pm_wr_en, ifc0.pm_wr_addr, ifc0.pm_wr_data,
                                 cpu_hold0, done0, error0}, 0);
        check("reset_outputs1", {ifc1.in_ready, ifc1.pm_wr_en, ifc1.pm_wr_addr, ifc1.pm_wr_data,
                                 cpu_hold1, done1, error1}, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("idle_ready", ifc0.in_ready, 1'b0);

        // Good three-byte load.
        pl = {8'h11, 8'h22, 8'h33};
        run_load(8'd3, pl, 8'h9A, 1'b0, 1'b0);

        // Same payload, bad checksum.
        run_load(8'd3, pl, 8'h00, 1'b0, 1'b0);

        // Wrap across the top of memory (visible on the FE instance).
        pl = {8'h01, 8'h02, 8'h03, 8'h04};
        run_load(8'd4, pl, 8'hF6, 1'b0, 1'b0);

        // Length zero means 256 bytes.
        pl.delete();
        for (int i = 0; i < 256; i++) pl.push_back(8'h01);
        run_load(8'd0, pl, 8'h00, 1'b0, 1'b0);

        // Random valid gaps and load_req pokes during DATA.
        pl = {8'h11, 8'h22, 8'h33};
        run_load(8'd3, pl, 8'h9A, 1'b1, 1'b1);

        // Abort mid-load with reset.
        obs0.delete();
        obs1.delete();
        pulse_load();
        send_byte(8'd4, 1'b0);
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        check("pre_reset_write", {ifc0.pm_wr_en, ifc0.pm_wr_addr, ifc0.pm_wr_data}, {1'b1, 8'h01, 8'hBB});
        reset = 1'b0;
        #1;
        check("abort_outputs0", {ifc0.in_ready, ifc0.pm_wr_en, ifc0.pm_wr_addr, ifc0.pm_wr_data,
                                 cpu_hold0, done0, error0}, 0);
        check("abort_outputs1", {ifc1.in_ready, ifc1.pm_wr_en, ifc1.pm_wr_addr, ifc1.pm_wr_data,
                                 cpu_hold1, done1, error1}, 0);
        @(negedge clk);
        reset = 1'b1;
        obs0.delete();
        obs1.delete();
        in_valid = 1'b1;
        in_data  = 8'h01;
        repeat (4) @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("no_load_without_req", {ifc0.in_ready, cpu_hold0, 8'(obs0.size())}, 0);

        pl = {8'h55};
        run_load(8'd1, pl, 8'hAB, 1'b0, 1'b0);

        // Random loads, alternating correct and arbitrary checksums.
        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(1, 7);
            pl.delete();
            for (int i = 0; i < n; i++) pl.push_back(8'($urandom));
            cs = (r % 2 == 0) ? good_csum(pl) : 8'($urandom);
            run_load(8'(n), pl, cs, 1'b1, r[0]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
